// File: rtl/rv32v_read_xbar_seq.sv
// Sequenced vector register-file read crossbar: captures one bank read, unpacks
// SEW8/16/32 elements into extended 32-bit lane words and streams them in beats.
package rv32v_read_xbar_seq_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [2:0] {
        SEW8  = 3'b000,
        SEW16 = 3'b001,
        SEW32 = 3'b010,
        SEW64 = 3'b011
    } vsew_t;
endpackage

module rv32v_read_xbar_seq
    import rv32v_read_xbar_seq_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = $clog2(4*NUM_LANES)+1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  word_t [NUM_LANES-1:0]       bank_dat,
    input  vsew_t                       veew,
    input  logic                        sign_ext,
    input  logic [CNT_W-1:0]            elem_cnt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output word_t [NUM_LANES-1:0]       out_dat,
    output logic [NUM_LANES-1:0]        out_mask,
    output logic                        out_last
);

    localparam int LOG_NL = $clog2(NUM_LANES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_r, state_nx_s;
    logic [1:0]             beat_r, beat_nx_s;
    word_t [NUM_LANES-1:0]  bank_r;
    logic [1:0]             plog_r;
    logic                   sext_r;
    logic [CNT_W-1:0]       ecnt_r;

    logic [1:0]             plog_in_s;
    logic [CNT_W-1:0]       cap_s;
    logic [CNT_W-1:0]       ecnt_in_s;
    logic [CNT_W-1:0]       beat_base_s;
    logic                   last_s;
    logic                   busy_s;
    logic                   hs_s;
    logic                   accept_s;
    logic                   load_s;

    // Element-size decode and element-count clamp for the incoming request
    always_comb begin
        plog_in_s = 2'd0;
        case (veew)
            SEW8:    plog_in_s = 2'd2;
            SEW16:   plog_in_s = 2'd1;
            default: plog_in_s = 2'd0;
        endcase
        cap_s     = CNT_W'(NUM_LANES) << plog_in_s;
        ecnt_in_s = (elem_cnt > cap_s) ? cap_s : elem_cnt;
    end

    // Handshake qualifiers; in_ready is forced low during flush or reset
    always_comb begin
        busy_s      = (state_r == BUSY);
        beat_base_s = CNT_W'(beat_r) << LOG_NL;
        last_s      = (beat_base_s + CNT_W'(NUM_LANES)) >= ecnt_r;
        hs_s        = busy_s && out_ready;
        in_ready    = !RST && !flush && (!busy_s || (hs_s && last_s));
        accept_s    = in_valid && in_ready;
        out_valid   = busy_s;
        out_last    = busy_s && last_s;
    end

    // Next-state logic: beat advance, group completion and back-to-back reload
    always_comb begin
        state_nx_s = state_r;
        beat_nx_s  = beat_r;
        load_s     = 1'b0;
        if (flush) begin
            state_nx_s = IDLE;
            beat_nx_s  = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        load_s     = 1'b1;
                        beat_nx_s  = 2'd0;
                        state_nx_s = (ecnt_in_s != '0) ? BUSY : IDLE;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                BUSY: begin
                    if (hs_s && last_s) begin
                        beat_nx_s = 2'd0;
                        if (accept_s) begin
                            load_s     = 1'b1;
                            state_nx_s = (ecnt_in_s != '0) ? BUSY : IDLE;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else if (hs_s) begin
                        beat_nx_s = beat_r + 2'd1;
                    end else begin
                        beat_nx_s = beat_r;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    beat_nx_s  = 2'd0;
                end
            endcase
        end
    end

    // State, beat counter and request holding registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            beat_r  <= 2'd0;
            bank_r  <= '0;
            plog_r  <= 2'd0;
            sext_r  <= 1'b0;
            ecnt_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            beat_r  <= beat_nx_s;
            if (load_s) begin
                bank_r <= bank_dat;
                plog_r <= plog_in_s;
                sext_r <= sign_ext;
                ecnt_r <= ecnt_in_s;
            end
        end
    end

    // Lane unpack from held bank words; inactive lanes and idle cycles drive zero
    always_comb begin
        logic [CNT_W-1:0] elem_v;
        logic [CNT_W-1:0] word_idx_v;
        word_t            src_v;
        logic [7:0]       byte_v;
        logic [15:0]      half_v;
        word_t            lane_v;
        out_dat  = '0;
        out_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            elem_v     = beat_base_s + CNT_W'(i);
            word_idx_v = elem_v >> plog_r;
            src_v      = '0;
            for (int j = 0; j < NUM_LANES; j++) begin
                src_v = (word_idx_v == CNT_W'(j)) ? bank_r[j] : src_v;
            end
            byte_v = src_v[{elem_v[1:0], 3'b000} +: 8];
            half_v = src_v[{elem_v[0], 4'b0000} +: 16];
            case (plog_r)
                2'd2:    lane_v = sext_r ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
                2'd1:    lane_v = sext_r ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
                default: lane_v = src_v;
            endcase
            out_mask[i] = busy_s && (elem_v < ecnt_r);
            out_dat[i]  = out_mask[i] ? lane_v : 32'd0;
        end
    end

endmodule
